// File: rtl/ripple_serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// master = producer of operands and consumer of results, slave = the subtractor.
interface ripple_serial_subtractor_if #(
  parameter int DATA_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] X;
  logic [DATA_W-1:0] Y;
  logic              B_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] D;
  logic              B_out;

  modport master (
    output in_valid, X, Y, B_in, out_ready,
    input  in_ready, out_valid, D, B_out
  );

  modport slave (
    input  in_valid, X, Y, B_in, out_ready,
    output in_ready, out_valid, D, B_out
  );
endinterface

// File: rtl/ripple_serial_subtractor.sv
// Bit-serial X - Y - B_in using one full-subtractor slice per cycle, LSB first.
// Optional macro SUB_SATURATE_EN clamps D to zero whenever the final borrow is set.
module ripple_serial_subtractor #(
  parameter int DATA_W = 6
) (
  input logic                        clk,
  input logic                        rst_n,
  ripple_serial_subtractor_if.slave  bus
);

  localparam int                CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              in_ready;
  logic              out_valid;
  logic              accept;

  logic [DATA_W-1:0] x_sh;
  logic [DATA_W-1:0] y_sh;
  logic [DATA_W-1:0] res_sh;
  logic [DATA_W-1:0] d_q;
  logic              borrow;
  logic              b_out_q;
  logic [CNT_W-1:0]  cnt;
  logic              d_bit;
  logic              b_bit;
  logic [DATA_W-1:0] d_full;

`ifdef SUB_SATURATE_EN
  function automatic logic [DATA_W-1:0] saturate_d(input logic [DATA_W-1:0] d,
                                                   input logic              b);
    return b ? '0 : d;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.D         = d_q;
  assign bus.B_out     = b_out_q;

  // Full-subtractor slice on the current LSBs; the last result bit lands in the MSB.
  always_comb begin
    d_bit  = x_sh[0] ^ y_sh[0] ^ borrow;
    b_bit  = (~x_sh[0] & y_sh[0]) | (~x_sh[0] & borrow) | (y_sh[0] & borrow);
    d_full = {d_bit, res_sh[DATA_W-1:1]};
  end

  // D/B_out only update on the final slice, so they keep the last result in IDLE/BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_sh    <= '0;
      y_sh    <= '0;
      res_sh  <= '0;
      d_q     <= '0;
      borrow  <= 1'b0;
      b_out_q <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      x_sh   <= bus.X;
      y_sh   <= bus.Y;
      borrow <= bus.B_in;
      cnt    <= '0;
    end else if (state == BUSY) begin
      x_sh   <= x_sh >> 1;
      y_sh   <= y_sh >> 1;
      borrow <= b_bit;
      res_sh <= d_full;
      cnt    <= cnt + 1'b1;
      if (cnt == LAST) begin
`ifdef SUB_SATURATE_EN
        d_q <= saturate_d(d_full, b_bit);
`else
        d_q <= d_full;
`endif
        b_out_q <= b_bit;
      end
    end
  end

endmodule

// File: tb/tb_ripple_serial_subtractor.sv
// Scoreboard bench: driver pushes model results, negedge monitor pops on each output handshake.
module tb_ripple_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ripple_serial_subtractor_if #(.DATA_W(6)) bus ();

  ripple_serial_subtractor #(.DATA_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [6:0] exp_q[$];
  int         cyc = 0;
  int         accept_cyc = -1;
  int         prev_accept = -1;
  logic       prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer subtraction, 7-bit two's complement of the difference.
  function automatic logic [6:0] model(input int x, input int y, input int b);
    int         diff;
    logic [6:0] r;
    diff = x - y - b;
    r    = diff[6:0];
`ifdef SUB_SATURATE_EN
    if (diff < 0) r = 7'h40;
`endif
    return r;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.out_valid && !prev_valid)
        check("latency", cyc - accept_cyc, 6);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          logic [6:0] e;
          e = exp_q.pop_front();
          check("result", int'({bus.B_out, bus.D}), int'(e));
        end
      end
      prev_valid = bus.out_valid;
    end
  end

  task automatic issue(input int x, input int y, input int b,
                       input bit expect_result, input bit check_interval);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      check("in_ready_timeout", 0, 1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.X        = 6'(x);
    bus.Y        = 6'(y);
    bus.B_in     = 1'(b);
    @(posedge clk);
    if (expect_result) exp_q.push_back(model(x, y, b));
    #1;
    prev_accept = accept_cyc;
    accept_cyc  = cyc;
    if (check_interval) check("issue_interval", accept_cyc - prev_accept, 8);
    // Scramble operands after acceptance; the result must not depend on them.
    bus.in_valid = 1'b0;
    bus.X        = 6'($urandom);
    bus.Y        = 6'($urandom);
    bus.B_in     = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         bad;
    int         waited;
    logic [6:0] hold_exp;

    bus.in_valid  = 1'b0;
    bus.X         = '0;
    bus.Y         = '0;
    bus.B_in      = 1'b0;
    bus.out_ready = 1'b0;

    #12;
    check("reset_in_ready", int'(bus.in_ready), 1);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_D", int'(bus.D), 0);
    check("reset_B_out", int'(bus.B_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    // Directed vectors
    issue(37, 21, 0, 1, 0);
    issue(5, 9, 0, 1, 1);
    issue(0, 0, 1, 1, 1);
    issue(63, 0, 0, 1, 1);
    drain();

    // Stall in DONE with out_ready low, in_valid offered meanwhile
    bus.out_ready = 1'b0;
    issue(5, 9, 0, 1, 0);
    hold_exp = model(5, 9, 0);
    waited = 0;
    while (!bus.out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("hold_reach_done", int'(bus.out_valid), 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.X        = 6'($urandom);
      bus.Y        = 6'($urandom);
      bus.B_in     = 1'($urandom);
      if (!bus.out_valid || {bus.B_out, bus.D} != hold_exp || bus.in_ready) bad++;
      @(negedge clk);
    end
    check("hold_stable_violations", bad, 0);
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("idle_after_release", int'(bus.in_ready), 1);
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      if (bus.out_valid || !bus.in_ready) bad++;
      @(negedge clk);
    end
    check("no_capture_in_done", bad, 0);
    drain();

    // Reset during the third BUSY cycle aborts the transaction
    issue(40, 3, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", int'(bus.in_ready), 1);
    check("abort_out_valid", int'(bus.out_valid), 0);
    check("abort_D", int'(bus.D), 0);
    check("abort_B_out", int'(bus.B_out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) bad++;
    end
    check("no_result_after_abort", bad, 0);
    issue(12, 3, 0, 1, 0);
    drain();
    check("after_abort_D", int'(bus.D), 9);

    // Back-to-back random transactions
    for (int i = 0; i < 1000; i++)
      issue(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
            int'($urandom_range(0, 1)), 1, i > 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
